uii2c_arb: RTL and testbench

UII2C_ARB -- requirements
Module: uii2c_arb

---
 rtl/uii2c_pkg.sv | 26 ++
 rtl/uii2c_rr_pick.sv | 27 ++
 rtl/uii2c_arb.sv | 148 ++++++++++++++
 tb/tb_uii2c_arb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uii2c_pkg.sv
// Shared I2C definitions: arbiter state encoding, requester limits and the
// per-requester transaction descriptor.
package uii2c_pkg;

    localparam int NREQ_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } i2c_state_e;

    typedef struct packed {
        logic [31:0] wr_data;
        logic [7:0]  wr_cnt;
        logic [7:0]  rd_cnt;
        logic        mode;
    } xact_t;

    // Owner index width for a given requester count (2 -> 1 bit, 3..4 -> 2 bits).
    function automatic int idx_w(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/uii2c_rr_pick.sv
// Round-robin picker: one-hot grant of the first requester found searching
// upward from (last_owner + 1) mod NREQ.
module uii2c_rr_pick
    import uii2c_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] gnt
);

    logic [IW:0]     sh;
    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] rot_gnt;

    // Rotate so the search start sits at bit 0, take the lowest set bit, rotate
    // back. sh is 1..NREQ, so the doubled vector covers every rotation.
    always_comb begin
        sh      = {1'b0, last_owner} + {{IW{1'b0}}, 1'b1};
        rot     = NREQ'({req, req} >> sh);
        rot_gnt = rot & (-rot);
        gnt     = NREQ'(({rot_gnt, rot_gnt} << sh) >> NREQ);
    end

endmodule

// File: rtl/uii2c_arb.sv
// Round-robin arbiter sharing one I2C master between NREQ requesters:
// grant, strobe iic_en until busy rises (or timeout), wait for busy to fall.
module uii2c_arb
    import uii2c_pkg::*;
#(
    parameter int          NREQ   = 2,
    parameter logic [15:0] TO_CYC = 16'd2047
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [32*NREQ-1:0]   wr_data_i,
    input  logic [8*NREQ-1:0]    wr_cnt_i,
    input  logic [8*NREQ-1:0]    rd_cnt_i,
    input  logic [NREQ-1:0]      mode_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic [7:0]           rd_data_o,
    output logic                 iic_en_o,
    output logic [31:0]          iic_wr_data_o,
    output logic [7:0]           iic_wr_cnt_o,
    output logic [7:0]           iic_rd_cnt_o,
    output logic                 iic_mode_o,
    input  logic                 iic_busy_i,
    input  logic [7:0]           iic_rd_data_i
);

    localparam int IW = idx_w(NREQ);

    i2c_state_e          state_q, state_d;
    xact_t [NREQ-1:0]    req_x;
    xact_t               sel_x, xact_q;
    logic [NREQ-1:0]     pick;
    logic [IW-1:0]       pick_idx, owner_q, last_owner_q;
    logic [15:0]         cnt_q, cnt_nxt;
    logic                grant_go, timeout;

    for (genvar k = 0; k < NREQ; k++) begin : g_req
        assign req_x[k] = '{
            wr_data: wr_data_i[32*k +: 32],
            wr_cnt:  wr_cnt_i[8*k +: 8],
            rd_cnt:  rd_cnt_i[8*k +: 8],
            mode:    mode_i[k]
        };
    end

    uii2c_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req        (req_i),
        .last_owner (last_owner_q),
        .gnt        (pick)
    );

    always_comb begin
        sel_x    = '0;
        pick_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick[k]) begin
                sel_x    = req_x[k];
                pick_idx = IW'(k);
            end
        end
    end

    assign grant_go = (|req_i) && !iic_busy_i;
    assign cnt_nxt  = (cnt_q >= TO_CYC) ? TO_CYC : cnt_q + 16'd1;
    assign timeout  = !iic_busy_i && (cnt_nxt == TO_CYC);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_go) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (iic_busy_i)   state_d = ST_WAIT;
                else if (timeout) state_d = ST_DONE;
            end
            ST_WAIT:  if (!iic_busy_i) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // done_o/err_o are set on the edge entering DONE so they coincide with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_o        <= '0;
            done_o       <= '0;
            err_o        <= '0;
            rd_data_o    <= '0;
            iic_en_o     <= 1'b0;
            xact_q       <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            cnt_q        <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_go) begin
                        gnt_o    <= pick;
                        owner_q  <= pick_idx;
                        xact_q   <= sel_x;
                        iic_en_o <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (iic_busy_i) begin
                        iic_en_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_nxt;
                        if (timeout) begin
                            iic_en_o <= 1'b0;
                            done_o   <= gnt_o;
                            err_o    <= gnt_o;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!iic_busy_i) begin
                        rd_data_o <= iic_rd_data_i;
                        done_o    <= gnt_o;
                    end
                end
                ST_DONE: begin
                    gnt_o        <= '0;
                    last_owner_q <= owner_q;
                end
                default: ;
            endcase
        end
    end

    assign iic_wr_data_o = xact_q.wr_data;
    assign iic_wr_cnt_o  = xact_q.wr_cnt;
    assign iic_rd_cnt_o  = xact_q.rd_cnt;
    assign iic_mode_o    = xact_q.mode;

endmodule

// File: tb/tb_uii2c_arb.sv
// Directed bench for uii2c_arb: two requesters, short timeout, hand-computed
// expectations for grant order, data mux, read capture, timeout and reset.
module tb_uii2c_arb;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_i = '0;
    logic [63:0] wr_data_i = {32'hA5A5_1234, 32'h0031_0878};
    logic [15:0] wr_cnt_i  = {8'd2, 8'd3};
    logic [15:0] rd_cnt_i  = {8'd1, 8'd0};
    logic [1:0]  mode_i    = 2'b01;
    logic [1:0]  gnt_o, done_o, err_o;
    logic [7:0]  rd_data_o;
    logic        iic_en_o;
    logic [31:0] iic_wr_data_o;
    logic [7:0]  iic_wr_cnt_o, iic_rd_cnt_o;
    logic        iic_mode_o;
    logic        iic_busy_i = 1'b0;
    logic [7:0]  iic_rd_data_i = '0;

    int n_vec = 0;
    int n_err = 0;
    int en_eps = 0;
    int done_cnt = 0;
    logic en_d = 1'b0;

    uii2c_arb #(.NREQ(2), .TO_CYC(16'd16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .wr_data_i     (wr_data_i),
        .wr_cnt_i      (wr_cnt_i),
        .rd_cnt_i      (rd_cnt_i),
        .mode_i        (mode_i),
        .gnt_o         (gnt_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .rd_data_o     (rd_data_o),
        .iic_en_o      (iic_en_o),
        .iic_wr_data_o (iic_wr_data_o),
        .iic_wr_cnt_o  (iic_wr_cnt_o),
        .iic_rd_cnt_o  (iic_rd_cnt_o),
        .iic_mode_o    (iic_mode_o),
        .iic_busy_i    (iic_busy_i),
        .iic_rd_data_i (iic_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        en_d <= iic_en_o;
        if (iic_en_o && !en_d) en_eps <= en_eps + 1;
        if (|done_o) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full transaction as the I2C master sees it; clr drops req bits in the done cycle.
    task automatic do_xact(input string tag, input int busy_cyc, input logic [7:0] rdb,
                           input logic [1:0] exp_g, input logic [31:0] exp_wd,
                           input logic [1:0] clr);
        int n = 0;
        while (!iic_en_o && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_en"}, {31'd0, iic_en_o}, 32'd1);
        if (!iic_en_o) return;
        chk({tag, "_gnt"}, {30'd0, gnt_o}, {30'd0, exp_g});
        chk({tag, "_wd"}, iic_wr_data_o, exp_wd);
        iic_busy_i = 1'b1;
        tick();
        chk({tag, "_en_drop"}, {31'd0, iic_en_o}, 32'd0);
        repeat (busy_cyc - 1) tick();
        chk({tag, "_nodone"}, {30'd0, done_o}, 32'd0);
        iic_rd_data_i = rdb;
        iic_busy_i    = 1'b0;
        tick();
        chk({tag, "_done"}, {30'd0, done_o}, {30'd0, exp_g});
        chk({tag, "_err"}, {30'd0, err_o}, 32'd0);
        chk({tag, "_rd"}, {24'd0, rd_data_o}, {24'd0, rdb});
        chk({tag, "_gnt_done"}, {30'd0, gnt_o}, {30'd0, exp_g});
        chk({tag, "_wd_hold"}, iic_wr_data_o, exp_wd);
        req_i = req_i & ~clr;
        tick();
        chk({tag, "_done_clr"}, {30'd0, done_o}, 32'd0);
        chk({tag, "_gnt_clr"}, {30'd0, gnt_o}, 32'd0);
    endtask

    initial begin
        int base_en, base_done, n;

        // reset state
        tick();
        tick();
        chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rst_done", {30'd0, done_o | err_o}, 32'd0);
        chk("rst_en", {31'd0, iic_en_o}, 32'd0);
        chk("rst_wd", iic_wr_data_o, 32'd0);
        chk("rst_cnt", {15'd0, iic_wr_cnt_o, iic_rd_cnt_o, iic_mode_o}, 32'd0);
        chk("rst_rd", {24'd0, rd_data_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        // single requester, long busy
        base_en = en_eps;
        base_done = done_cnt;
        req_i = 2'b01;
        do_xact("single", 20, 8'h00, 2'b01, 32'h0031_0878, 2'b01);
        chk("single_wcnt", {24'd0, iic_wr_cnt_o}, 32'd3);
        chk("single_mode", {31'd0, iic_mode_o}, 32'd1);
        tick();
        chk("single_en_eps", en_eps - base_en, 32'd1);
        chk("single_done_cnt", done_cnt - base_done, 32'd1);

        // read on requester 1
        req_i = 2'b10;
        do_xact("read", 3, 8'h56, 2'b10, 32'hA5A5_1234, 2'b10);
        chk("read_rcnt", {24'd0, iic_rd_cnt_o}, 32'd1);
        chk("read_mode", {31'd0, iic_mode_o}, 32'd0);

        // both held: strict alternation starting after last owner 1
        req_i = 2'b11;
        do_xact("rr0", 2, 8'h11, 2'b01, 32'h0031_0878, 2'b00);
        do_xact("rr1", 2, 8'h22, 2'b10, 32'hA5A5_1234, 2'b00);
        do_xact("rr2", 2, 8'h33, 2'b01, 32'h0031_0878, 2'b00);
        do_xact("rr3", 2, 8'h44, 2'b10, 32'hA5A5_1234, 2'b11);
        tick();

        // master busy when request arrives
        iic_busy_i = 1'b1;
        req_i = 2'b01;
        repeat (3) tick();
        chk("busy_nogrant", {30'd0, gnt_o}, 32'd0);
        chk("busy_noen", {31'd0, iic_en_o}, 32'd0);
        iic_busy_i = 1'b0;
        do_xact("busy_then", 2, 8'h9C, 2'b01, 32'h0031_0878, 2'b01);
        tick();

        // timeout: busy never rises
        req_i = 2'b01;
        n = 0;
        while (!iic_en_o && n < 10) begin
            tick();
            n++;
        end
        n = 0;
        while (iic_en_o && n < 40) begin
            tick();
            n++;
        end
        chk("to_en_cycles", n, 32'd16);
        chk("to_done", {30'd0, done_o}, 32'd1);
        chk("to_err", {30'd0, err_o}, 32'd1);
        chk("to_gnt", {30'd0, gnt_o}, 32'd1);
        req_i = 2'b00;
        tick();
        chk("to_clr", {28'd0, done_o, err_o}, 32'd0);
        chk("to_gnt_clr", {30'd0, gnt_o}, 32'd0);
        tick();

        // reset during WAIT abandons the transaction
        req_i = 2'b10;
        n = 0;
        while (!iic_en_o && n < 10) begin
            tick();
            n++;
        end
        chk("rstw_gnt", {30'd0, gnt_o}, 32'd2);
        iic_busy_i = 1'b1;
        tick();
        tick();
        base_done = done_cnt;
        rst_i = 1'b1;
        tick();
        chk("rstw_gnt0", {30'd0, gnt_o}, 32'd0);
        chk("rstw_en0", {31'd0, iic_en_o}, 32'd0);
        chk("rstw_done0", {28'd0, done_o, err_o}, 32'd0);
        chk("rstw_wd0", iic_wr_data_o, 32'd0);
        chk("rstw_rd0", {24'd0, rd_data_o}, 32'd0);
        rst_i = 1'b0;
        iic_busy_i = 1'b0;
        tick();
        chk("rstw_no_done", done_cnt - base_done, 32'd0);
        do_xact("rstw_after", 2, 8'h7E, 2'b10, 32'hA5A5_1234, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
